// File: rtl/johnson_monitor.sv
// Decoder and integrity checker for a 4-bit Johnson counter. It decodes the code
// to a phase index, flags illegal codes and illegal steps, tracks lock and counts errors.
module johnson_monitor #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 8,
  parameter bit          ALLOW_HOLD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [3:0]       code_in,
  input  logic             clr_err,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic             illegal_code,
  output logic             bad_step,
  output logic             wrap_pulse,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_sticky
);

  typedef enum logic {HUNT, LOCKED} state_e;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_e           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic             pv_q, pv_d;
  logic             ill_q, ill_d, bad_q, bad_d, wrap_q, wrap_d;
  logic             prev_valid_q, prev_valid_d;
  logic [3:0]       good_q, good_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             sticky_q, sticky_d;

  logic       legal, step_ok, err_evt;
  logic [2:0] idx;

  always_comb begin
    legal = 1'b1;
    idx   = 3'd0;
    case (code_in)
      4'h0: idx = 3'd0;
      4'h1: idx = 3'd1;
      4'h3: idx = 3'd2;
      4'h7: idx = 3'd3;
      4'hF: idx = 3'd4;
      4'hE: idx = 3'd5;
      4'hC: idx = 3'd6;
      4'h8: idx = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  // phase_q doubles as the previous legal index: both only load on legal samples.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pv_d         = pv_q;
    ill_d        = 1'b0;
    bad_d        = 1'b0;
    wrap_d       = 1'b0;
    prev_valid_d = prev_valid_q;
    good_d       = good_q;
    err_evt      = 1'b0;
    step_ok      = 1'b0;

    if (sample_en) begin
      if (!legal) begin
        ill_d        = 1'b1;
        pv_d         = 1'b0;
        prev_valid_d = 1'b0;
        good_d       = 4'd0;
        err_evt      = 1'b1;
      end else begin
        phase_d      = idx;
        pv_d         = 1'b1;
        prev_valid_d = 1'b1;
        if (prev_valid_q) begin
          step_ok = (idx == phase_q + 3'd1) || (ALLOW_HOLD && idx == phase_q);
          if (step_ok) begin
            if (good_q < LOCK_N) good_d = good_q + 4'd1;
            wrap_d = (phase_q == 3'd7) && (idx == 3'd0);
          end else begin
            bad_d   = 1'b1;
            good_d  = 4'd0;
            err_evt = 1'b1;
          end
        end
      end
    end

    if (step_ok && good_d == LOCK_N) state_d = LOCKED;
    if (err_evt)                     state_d = HUNT;

    err_d    = err_q;
    sticky_d = sticky_q;
    if (clr_err) begin
      err_d    = {{(ERR_W-1){1'b0}}, err_evt};
      sticky_d = err_evt;
    end else if (err_evt) begin
      if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HUNT;
      phase_q      <= 3'd0;
      pv_q         <= 1'b0;
      ill_q        <= 1'b0;
      bad_q        <= 1'b0;
      wrap_q       <= 1'b0;
      prev_valid_q <= 1'b0;
      good_q       <= 4'd0;
      err_q        <= '0;
      sticky_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      pv_q         <= pv_d;
      ill_q        <= ill_d;
      bad_q        <= bad_d;
      wrap_q       <= wrap_d;
      prev_valid_q <= prev_valid_d;
      good_q       <= good_d;
      err_q        <= err_d;
      sticky_q     <= sticky_d;
    end
  end

  assign phase        = phase_q;
  assign phase_valid  = pv_q;
  assign illegal_code = ill_q;
  assign bad_step     = bad_q;
  assign wrap_pulse   = wrap_q;
  assign locked       = (state_q == LOCKED);
  assign err_cnt      = err_q;
  assign err_sticky   = sticky_q;

endmodule

// File: tb/tb_johnson_monitor.sv
// Directed-vector bench for johnson_monitor: default, hold-allowed and 2-bit error
// counter instances, each driven by its own inputs and checked against a hand table.
module tb_johnson_monitor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       sen [3];
  logic       clr [3];
  logic [3:0] code [3];
  logic [2:0] ph [3];
  logic       pv [3], ill [3], bad [3], wr [3], lk [3], st [3];
  logic [7:0] e0, e1;
  logic [1:0] e2;

  johnson_monitor u0 (
    .clk(clk), .reset(reset), .sample_en(sen[0]), .code_in(code[0]), .clr_err(clr[0]),
    .phase(ph[0]), .phase_valid(pv[0]), .illegal_code(ill[0]), .bad_step(bad[0]),
    .wrap_pulse(wr[0]), .locked(lk[0]), .err_cnt(e0), .err_sticky(st[0]));

  johnson_monitor #(.ALLOW_HOLD(1'b1)) u1 (
    .clk(clk), .reset(reset), .sample_en(sen[1]), .code_in(code[1]), .clr_err(clr[1]),
    .phase(ph[1]), .phase_valid(pv[1]), .illegal_code(ill[1]), .bad_step(bad[1]),
    .wrap_pulse(wr[1]), .locked(lk[1]), .err_cnt(e1), .err_sticky(st[1]));

  johnson_monitor #(.ERR_W(2)) u2 (
    .clk(clk), .reset(reset), .sample_en(sen[2]), .code_in(code[2]), .clr_err(clr[2]),
    .phase(ph[2]), .phase_valid(pv[2]), .illegal_code(ill[2]), .bad_step(bad[2]),
    .wrap_pulse(wr[2]), .locked(lk[2]), .err_cnt(e2), .err_sticky(st[2]));

  typedef struct {
    int         dut;
    logic       sen;
    logic [3:0] code;
    logic       clr;
    logic [2:0] ph;
    logic       pv, ill, bad, wr, lk;
    int         err;
    logic       st;
    int         good;   // -1: not checked
  } vec_t;

  vec_t tbl[$];
  vec_t post[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t V(int d, logic s, logic [3:0] c, logic cl, logic [2:0] p,
                             logic v, logic i, logic b, logic w, logic l, int e,
                             logic t, int g);
    vec_t r;
    r.dut = d; r.sen = s; r.code = c; r.clr = cl; r.ph = p; r.pv = v; r.ill = i;
    r.bad = b; r.wr = w; r.lk = l; r.err = e; r.st = t; r.good = g;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] errv(int d);
    case (d)
      0:       return 32'(e0);
      1:       return 32'(e1);
      default: return 32'(e2);
    endcase
  endfunction

  function automatic logic [31:0] goodv(int d);
    case (d)
      0:       return 32'(u0.good_q);
      1:       return 32'(u1.good_q);
      default: return 32'(u2.good_q);
    endcase
  endfunction

  task automatic check_outs(string tag, vec_t v);
    int d = v.dut;
    chk({tag, ".phase"},        32'(ph[d]),  32'(v.ph));
    chk({tag, ".phase_valid"},  32'(pv[d]),  32'(v.pv));
    chk({tag, ".illegal_code"}, 32'(ill[d]), 32'(v.ill));
    chk({tag, ".bad_step"},     32'(bad[d]), 32'(v.bad));
    chk({tag, ".wrap_pulse"},   32'(wr[d]),  32'(v.wr));
    chk({tag, ".locked"},       32'(lk[d]),  32'(v.lk));
    chk({tag, ".err_cnt"},      errv(d),     32'(v.err));
    chk({tag, ".err_sticky"},   32'(st[d]),  32'(v.st));
    if (v.good >= 0) chk({tag, ".good_cnt"}, goodv(d), 32'(v.good));
  endtask

  task automatic apply(string tag, vec_t v);
    sen[v.dut]  = v.sen;
    code[v.dut] = v.code;
    clr[v.dut]  = v.clr;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin sen[k] = 1'b0; clr[k] = 1'b0; end
    @(negedge clk);
    check_outs(tag, v);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin sen[k] = 1'b0; clr[k] = 1'b0; code[k] = 4'h0; end
    reset = 1'b1;

    // default instance: clean run, lock, wrap
    tbl.push_back(V(0,1,4'h0,0, 0,1,0,0,0,0, 0,0, 0));
    tbl.push_back(V(0,1,4'h1,0, 1,1,0,0,0,0, 0,0, 1));
    tbl.push_back(V(0,1,4'h3,0, 2,1,0,0,0,0, 0,0, 2));
    tbl.push_back(V(0,1,4'h7,0, 3,1,0,0,0,0, 0,0, 3));
    tbl.push_back(V(0,1,4'hF,0, 4,1,0,0,0,1, 0,0, 4));
    tbl.push_back(V(0,1,4'hE,0, 5,1,0,0,0,1, 0,0, 4));
    tbl.push_back(V(0,1,4'hC,0, 6,1,0,0,0,1, 0,0, 4));
    tbl.push_back(V(0,1,4'h8,0, 7,1,0,0,0,1, 0,0, 4));
    tbl.push_back(V(0,1,4'h0,0, 0,1,0,0,1,1, 0,0, 4));
    // illegal code while locked, then recovery
    tbl.push_back(V(0,1,4'h5,0, 0,0,1,0,0,0, 1,1, 0));
    tbl.push_back(V(0,1,4'h0,0, 0,1,0,0,0,0, 1,1, 0));
    tbl.push_back(V(0,1,4'h1,0, 1,1,0,0,0,0, 1,1, 1));
    // skipped step, backward step, hold with hold disallowed
    tbl.push_back(V(0,1,4'h7,0, 3,1,0,1,0,0, 2,1, 0));
    tbl.push_back(V(0,1,4'h3,0, 2,1,0,1,0,0, 3,1, 0));
    tbl.push_back(V(0,1,4'h3,0, 2,1,0,1,0,0, 4,1, 0));
    // idle: pulses drop, state holds; then clear alone
    tbl.push_back(V(0,0,4'h9,0, 2,1,0,0,0,0, 4,1, 0));
    tbl.push_back(V(0,0,4'h0,1, 2,1,0,0,0,0, 0,0, 0));
    // two errors, then relock with err_cnt = 2
    tbl.push_back(V(0,1,4'h2,0, 2,0,1,0,0,0, 1,1, 0));
    tbl.push_back(V(0,1,4'hA,0, 2,0,1,0,0,0, 2,1, 0));
    tbl.push_back(V(0,1,4'h7,0, 3,1,0,0,0,0, 2,1, 0));
    tbl.push_back(V(0,1,4'hF,0, 4,1,0,0,0,0, 2,1, 1));
    tbl.push_back(V(0,1,4'hE,0, 5,1,0,0,0,0, 2,1, 2));
    tbl.push_back(V(0,1,4'hC,0, 6,1,0,0,0,0, 2,1, 3));
    tbl.push_back(V(0,1,4'h8,0, 7,1,0,0,0,1, 2,1, 4));
    // hold allowed: holds count as steps and can lock
    tbl.push_back(V(1,1,4'h3,0, 2,1,0,0,0,0, 0,0, 0));
    tbl.push_back(V(1,1,4'h3,0, 2,1,0,0,0,0, 0,0, 1));
    tbl.push_back(V(1,1,4'h3,0, 2,1,0,0,0,0, 0,0, 2));
    tbl.push_back(V(1,1,4'h7,0, 3,1,0,0,0,0, 0,0, 3));
    tbl.push_back(V(1,1,4'hF,0, 4,1,0,0,0,1, 0,0, 4));
    tbl.push_back(V(1,1,4'hF,0, 4,1,0,0,0,1, 0,0, 4));
    tbl.push_back(V(1,1,4'h0,0, 0,1,0,1,0,0, 1,1, 0));
    // 2-bit error counter: saturation and clear interactions
    tbl.push_back(V(2,1,4'h4,0, 0,0,1,0,0,0, 1,1, 0));
    tbl.push_back(V(2,1,4'h4,0, 0,0,1,0,0,0, 2,1, 0));
    tbl.push_back(V(2,1,4'h4,0, 0,0,1,0,0,0, 3,1, 0));
    tbl.push_back(V(2,1,4'h4,0, 0,0,1,0,0,0, 3,1, 0));
    tbl.push_back(V(2,1,4'h4,0, 0,0,1,0,0,0, 3,1, 0));
    tbl.push_back(V(2,0,4'h0,1, 0,0,0,0,0,0, 0,0, 0));
    tbl.push_back(V(2,1,4'h6,1, 0,0,1,0,0,0, 1,1, 0));
    tbl.push_back(V(2,1,4'h0,1, 0,1,0,0,0,0, 0,0, 0));

    // after a mid-sequence reset: first sample is unchecked, then steps count from zero
    post.push_back(V(0,1,4'h7,0, 3,1,0,0,0,0, 0,0, 0));
    post.push_back(V(0,1,4'hF,0, 4,1,0,0,0,0, 0,0, 1));
    post.push_back(V(0,1,4'hE,0, 5,1,0,0,0,0, 0,0, 2));

    #7;
    for (int d = 0; d < 3; d++)
      check_outs($sformatf("rst%0d", d), V(d,0,4'h0,0, 0,0,0,0,0,0, 0,0, 0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply($sformatf("v%0d", i), tbl[i]);

    // asynchronous reset between edges while locked with err_cnt = 2
    #2;
    reset = 1'b1;
    #1;
    check_outs("async", V(0,0,4'h0,0, 0,0,0,0,0,0, 0,0, 0));
    chk("async.prev_valid", 32'(u0.prev_valid_q), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < post.size(); i++) apply($sformatf("p%0d", i), post[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/johnson_monitor.md
# johnson_monitor

Checker and decoder that sits directly downstream of the 4-bit fault-recovering Johnson counter. It samples the counter's `count_out` and decodes each legal code to a 3-bit phase index. It flags illegal codes and illegal steps between consecutive samples, and it tracks lock status through a two-state FSM. Error counts are saturating, so system logic can observe counter upsets that the counter's own recovery path silently repairs.

## Interface
Parameters:
- `LOCK_COUNT`, default 4: consecutive legal steps required to enter LOCKED (range 1..15).
- `ERR_W`, default 8: width of the error counter.
- `ALLOW_HOLD`, default 0: 1 = an unchanged legal code between samples is a legal step; 0 = a hold is a bad step.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `sample_en`, in, 1: sample `code_in` on this rising edge.
- `code_in`, in, 4: Johnson code from the upstream counter.
- `clr_err`, in, 1: synchronous clear of `err_cnt` and `err_sticky`.
- `phase`, out, 3: decoded index of the last legal sample.
- `phase_valid`, out, 1: the last sample was a legal code.
- `illegal_code`, out, 1: one-cycle pulse; the last sample was an illegal code.
- `bad_step`, out, 1: one-cycle pulse; the last sample was legal, but not a legal successor of the previous one.
- `wrap_pulse`, out, 1: one-cycle pulse; a legal step from index 7 to index 0 occurred.
- `locked`, out, 1: the FSM is in LOCKED.
- `err_cnt`, out, `ERR_W`: saturating count of error samples.
- `err_sticky`, out, 1: set on any error; cleared only by `clr_err` or `reset`.

## Operation
Decode table:
- Index 0 to 7: codes 0x0, 0x1, 0x3, 0x7, 0xF, 0xE, 0xC, 0x8.
- Illegal codes: 0x2, 0x4, 0x5, 0x6, 0x9, 0xA, 0xB, 0xD.

Internal state:
- `prev_idx[2:0]` and `prev_valid` hold the last legal sample.
- `good_cnt[3:0]` counts consecutive legal steps.
- The FSM has two states, HUNT and LOCKED.

On each edge with `sample_en` = 1:
- **Illegal code:**
  - Assert `illegal_code`; set `phase_valid` = 0 and hold `phase`.
  - Set `prev_valid` = 0 and `good_cnt` = 0.
  - This sample is an error.
- **Legal code with `prev_valid` = 0:**
  - Update `phase` and set `phase_valid` = 1.
  - Load `prev_idx` and set `prev_valid` = 1.
  - No step check, not an error, and `good_cnt` is unchanged at 0.
- **Legal code with `prev_valid` = 1:**
  - Legal step means idx == (`prev_idx` + 1) mod 8, or idx == `prev_idx` when `ALLOW_HOLD` = 1.
  - On a legal step, increment `good_cnt`, saturating at `LOCK_COUNT`.
  - On a legal step from 7 to 0, also pulse `wrap_pulse`.
  - Otherwise pulse `bad_step`, set `good_cnt` = 0, and count the sample as an error.
  - In both cases, update `phase`, `phase_valid` and `prev_idx`.

FSM:
- HUNT to LOCKED when a legal step makes `good_cnt` reach `LOCK_COUNT`.
- LOCKED to HUNT on any error sample.
- Otherwise hold state.

Error accounting:
- An error sample increments `err_cnt`, saturating at 2^`ERR_W`-1, and sets `err_sticky`.
- `clr_err` alone: `err_cnt` = 0 and `err_sticky` = 0.
- `clr_err` together with an error sample: `err_cnt` = 1 and `err_sticky` = 1.

With `sample_en` = 0:
- Pulses deassert.
- All other state holds.
- `clr_err` is still honoured.

## Timing
- All outputs are registered and appear on the edge that samples `code_in`, i.e. they are visible 1 cycle after `code_in` is presented.
- `illegal_code`, `bad_step` and `wrap_pulse` are high for exactly one cycle per event. They are mutually exclusive.
- `locked` rises on the same edge as the `LOCK_COUNT`-th consecutive legal step. It falls on the same edge as the error.
- Reset asynchronously forces all of the following to 0, and the FSM to HUNT:
  - outputs `phase`, `phase_valid`, `illegal_code`, `bad_step`, `wrap_pulse`, `locked`, `err_cnt`, `err_sticky`;
  - internal state `prev_valid`, `prev_idx` and `good_cnt`.
- Reset mid-sequence discards the step history. The first sample after reset is never a bad step.
- Back-to-back samples are allowed every cycle. There is no minimum gap.

## Test plan
- **Clean run, lock and wrap:** reset, then `sample_en`=1 with codes 0x0, 0x1, 0x3, 0x7, 0xF, 0xE, 0xC, 0x8, 0x0. Required:
  - `phase` = 0..7, then 0;
  - `locked` rises on the 4th step (code 0xF);
  - `wrap_pulse` on the final sample;
  - `err_cnt` = 0.
- **Illegal code:** while LOCKED, present 0x5, then 0x0, then 0x1. Required:
  - `illegal_code` pulse, `phase_valid` = 0, `locked` = 0, `err_cnt` = 1;
  - 0x0 gives no `bad_step`;
  - 0x1 gives a legal step with `good_cnt` = 1.
- **Skipped step:** 0x1 then 0x7. Required: `bad_step` pulse, `phase` = 3, `err_cnt` increments, `locked` = 0.
- **Hold:** 0x3, 0x3. With `ALLOW_HOLD`=0, required: `bad_step`. With `ALLOW_HOLD`=1, required: no error and `good_cnt` increments.
- **Saturation and clear:** with `ERR_W`=2, inject 5 illegal codes. Required:
  - `err_cnt` holds at 3 after the 3rd error;
  - `clr_err` alone gives `err_cnt` = 0 and `err_sticky` = 0;
  - `clr_err` together with an illegal sample gives `err_cnt` = 1 and `err_sticky` = 1.
- **Async reset:** assert `reset` mid-cycle while LOCKED with `err_cnt` = 2. Required: all outputs are 0 immediately, before the next edge, and the first sample after release is not checked for a step.
